// File: rtl/jk_pkg.sv
// Shared definitions for the JK excitation driver: controller states and
// per-bit excitation codes, packed as {j, k}.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        FAIL  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } exc_t;

endpackage

// File: rtl/jk_excite.sv
// Single-bit JK excitation: picks the {j, k} pair that moves q to q_next.
// A changing bit may use either the explicit set/reset pair or a toggle.
module jk_excite
    import jk_pkg::*;
(
    input  logic q,
    input  logic q_next,
    input  logic use_toggle,
    output logic j,
    output logic k
);

    exc_t code;

    always_comb begin
        code = HOLD;
        if (q != q_next) begin
            if (use_toggle)
                code = TOGGLE;
            else if (q_next)
                code = SET;
            else
                code = RESET;
        end
    end

    assign {j, k} = code;

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives an external JK register to a requested state, verifies it through
// q_fb, re-drives on mismatch and latches err once retries run out.
//
// state | meaning
// IDLE  | ready for a new target, j/k held at zero
// DRIVE | j/k presented to the external register for one cycle
// CHECK | compare q_fb against the captured target, pass/retry/fail
// FAIL  | retries exhausted, terminal until rst
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tgt,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic             use_toggle,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    state_t           state, state_n;
    logic [WIDTH-1:0] tgt_cap, tgt_cap_n;
    logic             tog_cap, tog_cap_n;
    logic [RW-1:0]    retry, retry_n;
    logic [WIDTH-1:0] j_n, k_n;
    logic             done_n, err_n;

    logic [WIDTH-1:0] exc_target;
    logic             exc_tog;
    logic [WIDTH-1:0] exc_j, exc_k;

    assign tgt_ready = (state == IDLE);

    // In IDLE the table works on the incoming request; afterwards on the
    // captured one, so retries always chase the accepted target.
    assign exc_target = tgt_ready ? tgt : tgt_cap;
    assign exc_tog    = tgt_ready ? use_toggle : tog_cap;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_excite u_excite (
            .q          (q_fb[i]),
            .q_next     (exc_target[i]),
            .use_toggle (exc_tog),
            .j          (exc_j[i]),
            .k          (exc_k[i])
        );
    end

    always_comb begin
        state_n   = state;
        tgt_cap_n = tgt_cap;
        tog_cap_n = tog_cap;
        retry_n   = retry;
        j_n       = '0;
        k_n       = '0;
        done_n    = 1'b0;
        err_n     = err;
        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_cap_n = tgt;
                    tog_cap_n = use_toggle;
                    j_n       = exc_j;
                    k_n       = exc_k;
                    state_n   = DRIVE;
                end
            end
            DRIVE: state_n = CHECK;
            CHECK: begin
                if (q_fb == tgt_cap) begin
                    done_n  = 1'b1;
                    retry_n = '0;
                    state_n = IDLE;
                end else if (retry < RETRY_LIM) begin
                    retry_n = retry + RW'(1);
                    j_n     = exc_j;
                    k_n     = exc_k;
                    state_n = DRIVE;
                end else begin
                    err_n   = 1'b1;
                    state_n = FAIL;
                end
            end
            FAIL: err_n = 1'b1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tgt_cap <= '0;
            tog_cap <= 1'b0;
            retry   <= '0;
            j       <= '0;
            k       <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            tgt_cap <= tgt_cap_n;
            tog_cap <= tog_cap_n;
            retry   <= retry_n;
            j       <= j_n;
            k       <= k_n;
            done    <= done_n;
            err     <= err_n;
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: the DUT drives a behavioural 8-bit JK
// register with optional stuck-at-0 faults; results come from a table model.
module tb_jk_excitation_driver;

    logic       clk;
    logic       rst;
    logic [7:0] tgt;
    logic       tgt_valid;
    logic       tgt_ready;
    logic       use_toggle;
    logic [7:0] q_fb;
    logic [7:0] j;
    logic [7:0] k;
    logic       done;
    logic       err;

    logic [7:0] q_m;
    logic [7:0] stuck_perm;
    logic [7:0] stuck_once;
    logic [7:0] cur_q;

    int compared   = 0;
    int mismatched = 0;

    jk_excitation_driver #(.WIDTH(8), .MAX_RETRY(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .tgt        (tgt),
        .tgt_valid  (tgt_valid),
        .tgt_ready  (tgt_ready),
        .use_toggle (use_toggle),
        .q_fb       (q_fb),
        .j          (j),
        .k          (k),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Eight behavioural JK flip-flops; a stuck bit is forced to 0 on update.
    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (rst)
                q_m[b] <= 1'b0;
            else if (stuck_perm[b] || stuck_once[b])
                q_m[b] <= 1'b0;
            else
                case ({j[b], k[b]})
                    2'b01:   q_m[b] <= 1'b0;
                    2'b10:   q_m[b] <= 1'b1;
                    2'b11:   q_m[b] <= ~q_m[b];
                    default: q_m[b] <= q_m[b];
                endcase
        end
    end
    assign q_fb = q_m;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Excitation table: unchanged bits hold; a changing bit gets set/reset,
    // or both J and K when the toggle policy is selected.
    task automatic exc_model(input logic [7:0] q, input logic [7:0] t, input logic tog,
                             output logic [7:0] ej, output logic [7:0] ek);
        ej = '0;
        ek = '0;
        for (int b = 0; b < 8; b++) begin
            if (!q[b] && t[b]) begin
                ej[b] = 1'b1;
                ek[b] = tog;
            end else if (q[b] && !t[b]) begin
                ej[b] = tog;
                ek[b] = 1'b1;
            end
        end
    endtask

    task automatic run_txn(input logic [7:0] t, input logic tog, input logic [7:0] once_mask,
                           input int exp_retries);
        logic [7:0] ej, ek;
        int cyc;
        exc_model(cur_q, t, tog, ej, ek);
        @(negedge clk);
        chk("ready_idle", 32'(tgt_ready), 32'd1);
        tgt        = t;
        use_toggle = tog;
        tgt_valid  = 1'b1;
        @(negedge clk);
        cyc = 1;
        chk("drive_j", 32'(j), 32'(ej));
        chk("drive_k", 32'(k), 32'(ek));
        chk("ready_busy", 32'(tgt_ready), 32'd0);
        // Requests while busy carry a different target and must be ignored.
        tgt        = ~t;
        use_toggle = ~tog;
        stuck_once = once_mask;
        @(negedge clk);
        cyc = 2;
        stuck_once = '0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        tgt_valid = 1'b0;
        chk("done_latency", 32'(cyc), 32'(3 + 2 * exp_retries));
        chk("q_result", 32'(q_fb), 32'(t));
        chk("err_clear", 32'(err), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        cur_q = t;
    endtask

    initial begin
        logic [7:0] t;
        logic       tog;
        logic [7:0] mask;
        int         cyc;
        logic       saw_done;

        rst        = 1'b1;
        tgt        = '0;
        tgt_valid  = 1'b0;
        use_toggle = 1'b0;
        stuck_perm = '0;
        stuck_once = '0;
        cur_q      = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_j", 32'(j), 32'd0);
        chk("rst_k", 32'(k), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(tgt_ready), 32'd1);
        rst = 1'b0;

        // Set/reset policy from all-zero, then toggle policy on every bit.
        run_txn(8'hA5, 1'b0, 8'h00, 0);
        run_txn(8'hF0, 1'b0, 8'h00, 0);
        run_txn(8'h0F, 1'b1, 8'h00, 0);

        // Target equal to the present state still goes through DRIVE/CHECK.
        run_txn(8'h3C, 1'b0, 8'h00, 0);
        run_txn(8'h3C, 1'b1, 8'h00, 0);

        // Random targets and policies, some with a one-cycle stuck bit.
        for (int n = 0; n < 24; n++) begin
            t    = 8'($urandom_range(0, 255));
            tog  = 1'($urandom_range(0, 1));
            mask = '0;
            if ($urandom_range(0, 3) == 0)
                mask = t & (8'd1 << $urandom_range(0, 7));
            run_txn(t, tog, mask, (mask != 8'h00) ? 1 : 0);
        end

        // Bit 3 stuck for the first drive only: one retry, done at cycle 5.
        run_txn(8'h00, 1'b0, 8'h00, 0);
        run_txn(8'h08, 1'b0, 8'h08, 1);

        // Bit 0 stuck permanently: four failed checks, then FAIL.
        stuck_perm = 8'h01;
        @(negedge clk);
        tgt        = 8'h01;
        use_toggle = 1'b0;
        tgt_valid  = 1'b1;
        @(negedge clk);
        cyc = 1;
        tgt_valid = 1'b0;
        chk("fail_drive_j", 32'(j), 32'h01);
        chk("fail_drive_k", 32'(k), 32'h08);
        saw_done = 1'b0;
        while (err !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("err_latency", 32'(cyc), 32'd9);
        chk("fail_no_done", 32'(saw_done), 32'd0);
        chk("fail_ready", 32'(tgt_ready), 32'd0);
        chk("fail_jk", 32'({j, k}), 32'd0);
        tgt        = 8'h55;
        use_toggle = 1'b1;
        tgt_valid  = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("fail_hold_ready", 32'(tgt_ready), 32'd0);
            chk("fail_hold_err", 32'(err), 32'd1);
            chk("fail_hold_jk", 32'({j, k, done}), 32'd0);
        end
        chk("fail_q_unchanged", 32'(q_fb), 32'h00);
        tgt_valid  = 1'b0;
        stuck_perm = '0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cur_q = '0;
        chk("fail_rst_err", 32'(err), 32'd0);
        chk("fail_rst_ready", 32'(tgt_ready), 32'd1);

        // Reset asserted during CHECK overrides the pending done.
        @(negedge clk);
        tgt        = 8'h5A;
        use_toggle = 1'b0;
        tgt_valid  = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("chk_rst_jk", 32'({j, k}), 32'd0);
        chk("chk_rst_done", 32'(done), 32'd0);
        chk("chk_rst_err", 32'(err), 32'd0);
        chk("chk_rst_ready", 32'(tgt_ready), 32'd1);
        @(negedge clk);
        chk("chk_rst_no_done", 32'(done), 32'd0);
        cur_q = '0;
        run_txn(8'hC3, 1'b1, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/jk_excitation_driver.md
JK_EXCITATION_DRIVER -- requirements
Module: jk_excitation_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of external JK flip-flops driven.
REQ-002 The block SHALL have parameter MAX_RETRY, default 3, giving the number of re-drive attempts after a failed check.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-005 The block SHALL have port tgt, input, WIDTH bits: the requested next state of the external register.
REQ-006 The block SHALL have port tgt_valid, input, 1 bit: tgt is valid.
REQ-007 The block SHALL have port tgt_ready, output, 1 bit: the block accepts tgt this cycle.
REQ-008 The block SHALL have port use_toggle, input, 1 bit: don't-care resolution policy, sampled at accept.
REQ-009 The block SHALL have port q_fb, input, WIDTH bits: the q outputs of the external JK register.
REQ-010 The block SHALL have port j, output, WIDTH bits: the J drive to the external register.
REQ-011 The block SHALL have port k, output, WIDTH bits: the K drive to the external register.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse on a successful update.
REQ-013 The block SHALL have port err, output, 1 bit: a sticky flag set when retries are exhausted.

Function
REQ-014 The block SHALL implement states IDLE, DRIVE, CHECK and FAIL.
REQ-015 tgt_ready SHALL be high only in IDLE; an accept SHALL occur when tgt_valid and tgt_ready are both high.
REQ-016 On accept, the block SHALL capture tgt and use_toggle, compute j and k per bit from (q_fb, tgt), register them, and enter DRIVE.
REQ-017 The per-bit excitation SHALL follow this table:
- 0->0: J=0, K=0.
- 1->1: J=0, K=0.
- 0->1: use_toggle=0 gives J=1, K=0; use_toggle=1 gives J=1, K=1.
- 1->0: use_toggle=0 gives J=0, K=1; use_toggle=1 gives J=1, K=1.
REQ-018 j and k SHALL hold their computed values for exactly the one DRIVE cycle and SHALL be all-zero (hold) in every other state.
REQ-019 The block SHALL move from DRIVE to CHECK unconditionally, so that q_fb reflects the external flip-flop update in CHECK.
REQ-020 In CHECK, if q_fb equals the captured target, the block SHALL pulse done for one cycle, clear the retry count and return to IDLE.
REQ-021 In CHECK, on a mismatch with retry count below MAX_RETRY, the block SHALL increment the count, recompute j and k from the current q_fb and the captured target, and re-enter DRIVE.
REQ-022 In CHECK, on a mismatch with retry count equal to MAX_RETRY, the block SHALL enter FAIL and set err.
REQ-023 FAIL SHALL be terminal until rst: tgt_ready low, j and k zero, err high.
REQ-024 Per-transaction latency SHALL be 3 cycles from accept to done with no retries, plus 2 cycles per retry.
REQ-025 A target equal to q_fb at accept SHALL still pass through DRIVE (all-zero drive) and CHECK, then pulse done.
REQ-026 The retry counter SHALL be clog2(MAX_RETRY+1) bits wide and SHALL never wrap.
REQ-027 A tgt_valid asserted outside IDLE SHALL be ignored and SHALL NOT be captured.

Reset
REQ-028 rst SHALL be sampled on the clk rising edge and SHALL take priority over all other activity, including mid-DRIVE or mid-CHECK.
REQ-029 After reset the block SHALL be in IDLE with j=0, k=0, done=0, err=0, tgt_ready=1, retry count 0 and captured target 0.

Structure
REQ-030 The state encoding and the excitation-code constants (HOLD, RESET, SET, TOGGLE) SHALL reside in shared package jk_pkg.
REQ-031 The per-bit excitation table SHALL be a combinational sub-module jk_excite (inputs q, q_next, use_toggle; outputs j, k), instantiated WIDTH times via generate.
REQ-032 All outputs SHALL be registered, except tgt_ready, which SHALL be decoded from the state register.

Verification
REQ-033 Bench: the DUT SHALL be wired to WIDTH instances of a behavioural JK flip-flop; with q_fb=8'h00, tgt=8'hA5 and use_toggle=0, the DRIVE cycle SHALL show j=8'hA5, k=8'h00, and done SHALL pulse 3 cycles after accept with q_fb=8'hA5.
REQ-034 Bench: with q_fb=8'hF0, tgt=8'h0F and use_toggle=1, the DRIVE cycle SHALL show j=k=8'hFF, and done SHALL follow with q_fb=8'h0F.
REQ-035 Bench: with bit 3 of the model forced stuck at 0 for one cycle, tgt=8'h08 SHALL cause one retry and then done, 5 cycles after accept.
REQ-036 Bench: with bit 0 stuck at 0 permanently and tgt=8'h01, err SHALL rise after 4 CHECK mismatches with tgt_ready low, and a later tgt_valid SHALL be ignored until rst.
REQ-037 Bench: asserting rst during the CHECK cycle SHALL, on the next edge, give IDLE with j=k=0, done=0, err=0 and tgt_ready=1.
REQ-038 Bench: with tgt equal to q_fb=8'h3C, j=k=0 SHALL be observed in DRIVE and done SHALL still pulse at cycle 3.
